// File: rtl/padder.sv
// rtl/padder.sv - re-embeds a cropped pixel stream into a full frame behind a show-ahead FIFO
// Optional ring border around the window: define PADDER_BORDER_EN (adds BORDER_COLOR).
module padder #(
    parameter logic [11:0] H_DISP      = 12'd1280,
    parameter logic [11:0] V_DISP      = 12'd720,
    parameter int          X_RES_WIDTH = 11,
    parameter int          Y_RES_WIDTH = 11,
    parameter int          FIFO_AW     = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   EN,
    input  logic [X_RES_WIDTH-1:0] START_X,
    input  logic [Y_RES_WIDTH-1:0] START_Y,
    input  logic [X_RES_WIDTH-1:0] END_X,
    input  logic [Y_RES_WIDTH-1:0] END_Y,
`ifdef PADDER_BORDER_EN
    input  logic [23:0]            BORDER_COLOR,
`endif
    input  logic [23:0]            BG_COLOR,
    input  logic                   pre_vs,
    input  logic                   pre_de,
    input  logic [23:0]            pre_data,
    input  logic                   tim_vs,
    input  logic                   tim_de,
    output logic                   post_vs,
    output logic                   post_de,
    output logic [23:0]            post_data,
    output logic                   underflow,
    output logic                   overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [X_RES_WIDTH-1:0] H_LAST = X_RES_WIDTH'(H_DISP - 12'd1);
    localparam logic [Y_RES_WIDTH-1:0] V_LAST = Y_RES_WIDTH'(V_DISP - 12'd1);
    localparam logic [FIFO_AW:0]       FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [X_RES_WIDTH-1:0] h_cnt;
    logic [Y_RES_WIDTH-1:0] v_cnt;
    logic                   tim_vs_d;
    logic [23:0]            mem [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr;
    logic [FIFO_AW-1:0]     rd_ptr;
    logic [FIFO_AW:0]       count;

    logic in_win, full, empty, flush, wr_req, wr_en, pop, uf_set, of_set, vs_rise;
    logic [23:0] head;
    logic [23:0] fill_color;

    assign in_win = (h_cnt >= START_X) && (h_cnt < END_X) &&
                    (v_cnt >= START_Y) && (v_cnt < END_Y);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign flush   = pre_vs | ~EN;
    assign wr_req  = pre_de & EN & ~pre_vs;
    assign pop     = EN & tim_de & ~tim_vs & in_win & ~empty;
    // A full FIFO still accepts a write when a pop frees the head slot this cycle.
    assign wr_en   = wr_req & (~full | pop);
    assign of_set  = wr_req & full & ~pop;
    assign uf_set  = EN & tim_de & ~tim_vs & in_win & empty;
    assign vs_rise = tim_vs & ~tim_vs_d;
    assign head    = mem[rd_ptr];

`ifdef PADDER_BORDER_EN
    logic h_left, h_right, v_top, v_bot, h_span, v_span, on_ring;
    assign h_left  = (START_X != '0) && (h_cnt == START_X - 1'b1);
    assign h_right = (h_cnt == END_X);
    assign v_top   = (START_Y != '0) && (v_cnt == START_Y - 1'b1);
    assign v_bot   = (v_cnt == END_Y);
    // A zero start edge has no ring cell at -1, so the span simply starts at 0.
    assign h_span  = ((START_X == '0) || (h_cnt >= START_X - 1'b1)) && (h_cnt <= END_X);
    assign v_span  = ((START_Y == '0) || (v_cnt >= START_Y - 1'b1)) && (v_cnt <= END_Y);
    assign on_ring = ~in_win && ((((h_left | h_right) && v_span)) || ((v_top | v_bot) && h_span));
    assign fill_color = on_ring ? BORDER_COLOR : BG_COLOR;
`else
    assign fill_color = BG_COLOR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            tim_vs_d <= 1'b0;
        end else begin
            tim_vs_d <= tim_vs;
            if (tim_vs) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (tim_de) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pre_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= 24'h0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (EN) begin
            post_vs <= tim_vs;
            post_de <= tim_de;
            if (pop)         post_data <= head;
            else if (tim_de) post_data <= fill_color;
            else             post_data <= 24'h0;
            underflow <= uf_set | (underflow & ~vs_rise);
            overflow  <= of_set | (overflow & ~vs_rise);
        end else begin
            post_vs   <= pre_vs;
            post_de   <= pre_de;
            post_data <= pre_data;
        end
    end
endmodule

// File: tb/tb_padder.sv
// tb/tb_padder.sv - directed self-checking bench for padder on a 16x8 frame
module tb_padder;
    localparam logic [23:0] BG = 24'h0000FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [10:0] start_x = 11'd4, end_x = 11'd8;
    logic [10:0] start_y = 11'd2, end_y = 11'd4;
    logic [23:0] bg_color = BG;
    logic        pre_vs = 1'b0, pre_de = 1'b0;
    logic [23:0] pre_data = 24'h0;
    logic        tim_vs = 1'b0, tim_de = 1'b0;

    logic        a_vs, a_de, a_uf, a_of;
    logic [23:0] a_data;
    logic        b_vs, b_de, b_uf, b_of;
    logic [23:0] b_data;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_a [8];
    logic [23:0] exp_b [8];

    padder #(.H_DISP(12'd16), .V_DISP(12'd8), .X_RES_WIDTH(11), .Y_RES_WIDTH(11), .FIFO_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .EN(en),
        .START_X(start_x), .START_Y(start_y), .END_X(end_x), .END_Y(end_y),
        .BG_COLOR(bg_color), .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
        .tim_vs(tim_vs), .tim_de(tim_de),
        .post_vs(a_vs), .post_de(a_de), .post_data(a_data), .underflow(a_uf), .overflow(a_of)
    );

    padder #(.H_DISP(12'd16), .V_DISP(12'd8), .X_RES_WIDTH(11), .Y_RES_WIDTH(11), .FIFO_AW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .EN(en),
        .START_X(start_x), .START_Y(start_y), .END_X(end_x), .END_Y(end_y),
        .BG_COLOR(bg_color), .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
        .tim_vs(tim_vs), .tim_de(tim_de),
        .post_vs(b_vs), .post_de(b_de), .post_data(b_data), .underflow(b_uf), .overflow(b_of)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int n, input logic [23:0] base);
        pre_vs = 1'b1;
        tick();
        pre_vs = 1'b0;
        for (int i = 0; i < n; i++) begin
            pre_de   = 1'b1;
            pre_data = base + 24'(i);
            tick();
        end
        pre_de = 1'b0;
        tick();
    endtask

    // Drives one vsync then npix raster pixels; checks both instances pixel by pixel.
    task automatic run_frame(input int na, input int nb, input bit wr_win, input int npix);
        tim_vs = 1'b1;
        tick();
        tim_vs = 1'b0;
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 16; h++) begin
                if (v * 16 + h < npix) begin
                    bit win;
                    int idx;
                    logic [23:0] ea, eb;
                    win = (h >= 4) && (h < 8) && (v >= 2) && (v < 4);
                    idx = (v - 2) * 4 + (h - 4);
                    ea = (win && idx < na) ? exp_a[idx] : BG;
                    eb = (win && idx < nb) ? exp_b[idx] : BG;
                    tim_de   = 1'b1;
                    pre_de   = wr_win && win && (v == 2);
                    pre_data = (wr_win && win && (v == 2)) ? exp_b[idx + 4] : 24'h0;
                    tick();
                    check($sformatf("pix_a v%0d h%0d", v, h), a_data, ea);
                    check($sformatf("pix_b v%0d h%0d", v, h), b_data, eb);
                    if (wr_win && win && (v == 2))
                        check("t4_count_full", 24'(dut_s.count), 24'd4);
                end
            end
        end
        tim_de = 1'b0;
        pre_de = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_post_vs", 24'(a_vs), 24'd0);
        check("rst_post_de", 24'(a_de), 24'd0);
        check("rst_post_data", a_data, 24'h0);
        check("rst_underflow", 24'(a_uf), 24'd0);
        check("rst_overflow", 24'(a_of), 24'd0);
        check("rst_count", 24'(dut.count), 24'd0);
        rst_n = 1'b1;
        tick();

        // Full window of 8 pixels.
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 24'h1 + 24'(i);
            exp_b[i] = 24'h1 + 24'(i);
        end
        preload(8, 24'h1);
        check("t1_count_loaded", 24'(dut.count), 24'd8);
        run_frame(8, 4, 1'b0, 128);
        check("t1_underflow", 24'(a_uf), 24'd0);
        check("t1_overflow", 24'(a_of), 24'd0);
        check("t1_count_end", 24'(dut.count), 24'd0);

        // Starvation after 5 pixels.
        preload(5, 24'h1);
        run_frame(5, 4, 1'b0, 128);
        check("t2_underflow_set", 24'(a_uf), 24'd1);
        tim_vs = 1'b1;
        tick();
        tim_vs = 1'b0;
        check("t2_underflow_clr", 24'(a_uf), 24'd0);
        check("t2_overflow_clr_s", 24'(b_of), 24'd0);

        // Overflow on the depth-4 instance.
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 24'hA1 + 24'(i);
            exp_b[i] = 24'hA1 + 24'(i);
        end
        preload(6, 24'hA1);
        check("t3_overflow_s", 24'(b_of), 24'd1);
        check("t3_overflow_a", 24'(a_of), 24'd0);
        check("t3_count_s", 24'(dut_s.count), 24'd4);
        run_frame(6, 4, 1'b0, 128);

        // Write and pop together while full.
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 24'hB1 + 24'(i);
            exp_b[i] = 24'hB1 + 24'(i);
        end
        preload(4, 24'hB1);
        check("t4_count_pre", 24'(dut_s.count), 24'd4);
        run_frame(8, 8, 1'b1, 128);
        check("t4_overflow_s", 24'(b_of), 24'd0);
        check("t4_underflow_s", 24'(b_uf), 24'd0);
        check("t4_count_end", 24'(dut_s.count), 24'd0);

        // Bypass.
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pre_vs   = (i < 2);
            pre_de   = (i >= 3);
            pre_data = 24'h10 + 24'(i);
            tick();
            check($sformatf("t5_data %0d", i), a_data, 24'h10 + 24'(i));
            check($sformatf("t5_de %0d", i), 24'(a_de), (i >= 3) ? 24'd1 : 24'd0);
            check($sformatf("t5_vs %0d", i), 24'(a_vs), (i < 2) ? 24'd1 : 24'd0);
        end
        pre_vs = 1'b0;
        pre_de = 1'b0;
        pre_data = 24'h0;
        en = 1'b1;
        tick();

        // Reset while the timing is about to enter the window.
        preload(3, 24'hC1);
        check("t6_count_pre", 24'(dut.count), 24'd3);
        tim_vs = 1'b1;
        tick();
        tim_vs = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tim_de = 1'b1;
            tick();
        end
        check("t6_de_before_rst", 24'(a_de), 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_de", 24'(a_de), 24'd0);
        check("t6_rst_data", a_data, 24'h0);
        check("t6_rst_count", 24'(dut.count), 24'd0);
        tim_de = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(0, 0, 1'b0, 128);
        check("t6_underflow", 24'(a_uf), 24'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/padder.md
Name: padder

Overview:
- Inverse of the crop stage in the video processing (VP) chain: re-embeds a cropped pixel stream into a full H_DISP x V_DISP frame.
- Cropped pixels (pre_*) are buffered in an internal show-ahead FIFO.
- They are replayed when a downstream full-frame timing (tim_vs/tim_de, from the display timing generator) enters the window [START_X,END_X) x [START_Y,END_Y).
- Outside the window, and on starvation, it outputs BG_COLOR.

Parameters:
H_DISP, 12'd1280, horizontal resolution of output frame
V_DISP, 12'd720, vertical resolution of output frame
X_RES_WIDTH, 11, width of X coordinate inputs and h counter
Y_RES_WIDTH, 11, width of Y coordinate inputs and v counter
FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW pixels

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
EN  input  1  1 = pad mode, 0 = bypass
START_X  input  X_RES_WIDTH  window left edge (inclusive)
START_Y  input  Y_RES_WIDTH  window top edge (inclusive)
END_X  input  X_RES_WIDTH  window right edge (exclusive)
END_Y  input  Y_RES_WIDTH  window bottom edge (exclusive)
BG_COLOR  input  24  fill colour outside window / on underflow
pre_vs  input  1  cropped stream vsync, active-high level
pre_de  input  1  cropped stream pixel valid
pre_data  input  24  cropped stream pixel
tim_vs  input  1  output-frame timing vsync, active-high level
tim_de  input  1  output-frame timing data enable
post_vs  output  1  output vsync
post_de  output  1  output data enable
post_data  output  24  output pixel
underflow  output  1  sticky: window pixel requested with FIFO empty
overflow  output  1  sticky: pre_de pixel dropped on FIFO full

Behaviour:
- Reset: all outputs 0; FIFO empty; h_cnt = 0, v_cnt = 0.
- Counters (output timing domain):
  - tim_vs high: h_cnt = v_cnt = 0.
  - Otherwise on tim_de: h_cnt increments; at H_DISP-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_DISP-1 to 0.
- in_win = (h_cnt>=START_X) & (h_cnt<END_X) & (v_cnt>=START_Y) & (v_cnt<END_Y), evaluated on current counter values (before increment).
- FIFO write: pre_de & EN & !pre_vs & !full writes pre_data.
  - pre_de while full: pixel dropped, overflow <= 1.
- FIFO flush: pre_vs high or EN low empties the FIFO. Flush has priority over a simultaneous write.
- FIFO read (pop) = EN & tim_de & !tim_vs & in_win & !empty.
  - Simultaneous read and write when full is legal: count unchanged, no overflow.
  - Same when empty: the write lands and the read does not occur (show-ahead requires the data to be present first).
- Output, latency 1 cycle from tim_*:
  - post_vs <= tim_vs; post_de <= tim_de.
  - post_data <= fifo head if popping; else BG_COLOR if tim_de; else 24'h0.
- Window request (tim_de & in_win & !tim_vs) with FIFO empty: post_data = BG_COLOR and underflow <= 1.
- underflow and overflow: cleared on the first cycle tim_vs is high; a set event in that same cycle wins.
- Bypass (EN=0): post_vs <= pre_vs, post_de <= pre_de, post_data <= pre_data, latency 1. Counters keep running on tim_*. Flags hold their values.
- Degenerate window:
  - START_X>=END_X or START_Y>=END_Y: in_win never true, full BG frame.
  - END beyond H_DISP/V_DISP: clipped naturally by counter range.
- FIFO: single-clock, registered count of width FIFO_AW+1; full = count==2**FIFO_AW; empty = count==0.

Optional Feature:
- PADDER_BORDER_EN defined: adds input BORDER_COLOR[23:0].
  - Any tim_de pixel on the 1-pixel ring just outside the window gets post_data = BORDER_COLOR. Ring: h_cnt==START_X-1 or h_cnt==END_X with v in [START_Y-1,END_Y], or the same for rows.
  - Ring positions with START_X==0 or START_Y==0 are not drawn (no negative wrap).
  - Border never pops the FIFO.
- Undefined: no BORDER_COLOR port; ring positions get BG_COLOR.

Test Plan:
1. H_DISP=16, V_DISP=8, window X 4..8, Y 2..4, BG=0x0000FF; preload 8 pixels 0x000001..0x000008 before frame -> rows 2,3 cols 4..7 carry 1..8 in raster order one cycle after tim_de; all other 120 tim_de pixels are 0x0000FF; underflow=0, FIFO empty at frame end.
2. Same window, only 5 pixels preloaded -> pixels 1..5 out, remaining 3 window positions BG_COLOR; underflow=1 until next tim_vs, then 0.
3. FIFO_AW=2, 6 pre_de pixels with no reads -> first 4 stored, overflow=1; the 2 extra never appear on post_data.
4. Write and read on same cycle with FIFO full (4 entries) -> no overflow; count stays 4; output order preserved.
5. EN=0, pre_data ramp 0x10..0x1F -> post_data equals pre_data delayed by exactly 1 clk; post_de/post_vs follow pre_de/pre_vs.
6. rst_n asserted mid-window with 3 pixels queued -> outputs 0 immediately, FIFO empty; after release, next frame window is all BG with underflow=1 unless refilled.
